// File: rtl/seq_pkg.sv
// Shared sequencing types: controller FSM states and the command word width.
package seq_pkg;

   localparam int unsigned CMD_WIDTH = 32;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LATCH = 2'd1,
      ST_GAP   = 2'd2
   } seq_state_e;

endpackage : seq_pkg

// File: rtl/sync_fifo_mem.sv
// Synchronous FIFO storage with pointers, occupancy count and full/empty flags.
// A push into a full FIFO is accepted only when a pop happens on the same edge.
module sync_fifo_mem #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned DEPTH      = 8,
   parameter int unsigned ADDR_WIDTH = 3
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  flush,
   input  logic                  push,
   input  logic                  pop,
   input  logic [DATA_WIDTH-1:0] wr_data,
   output logic [DATA_WIDTH-1:0] rd_data_c,
   output logic [ADDR_WIDTH:0]   count,
   output logic                  empty,
   output logic                  full
);

   localparam int unsigned CNT_W = ADDR_WIDTH + 1;

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [ADDR_WIDTH-1:0] wr_ptr;
   logic [ADDR_WIDTH-1:0] rd_ptr;
   logic [CNT_W-1:0]      count_next;
   logic                  push_ok;
   logic                  pop_ok;

   // Qualify requests against the current occupancy.
   always_comb begin
      pop_ok     = pop && !empty;
      push_ok    = push && (!full || pop_ok);
      count_next = count;
      unique case ({push_ok, pop_ok})
         2'b10:   count_next = count + CNT_W'(1);
         2'b01:   count_next = count - CNT_W'(1);
         default: count_next = count;
      endcase
   end

   assign rd_data_c = mem[rd_ptr];

   // Storage has no reset; only the pointer-selected entries are ever read.
   always_ff @(posedge clock) begin
      if (push_ok && !flush) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   always_ff @(posedge clock) begin
      if (reset || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         empty  <= 1'b1;
         full   <= 1'b0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
         if (pop_ok)  rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
         count <= count_next;
         empty <= (count_next == CNT_W'(0));
         full  <= (count_next == CNT_W'(DEPTH));
      end
   end

endmodule : sync_fifo_mem

// File: rtl/cmd_word_fifo.sv
// Buffers SPI command words and replays them as a held cmd_data bus with a
// single-cycle latch_data strobe followed by a fixed idle gap.
module cmd_word_fifo
   import seq_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = CMD_WIDTH,
   parameter int unsigned DEPTH      = 8,
   parameter int unsigned ADDR_WIDTH = 3,
   parameter int unsigned LATCH_GAP  = 2
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  wr_valid,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  flush,
   input  logic                  sink_ready,
   input  logic                  clear_overflow,
   output logic [DATA_WIDTH-1:0] cmd_data,
   output logic                  latch_data,
   output logic [ADDR_WIDTH:0]   fifo_count,
   output logic                  empty,
   output logic                  full,
   output logic                  overflow
);

   localparam int unsigned GAP_W    = (LATCH_GAP > 1) ? $clog2(LATCH_GAP) : 1;
   localparam int unsigned GAP_LAST = (LATCH_GAP > 0) ? LATCH_GAP - 1 : 0;

   seq_state_e            state;
   seq_state_e            state_next;
   logic [GAP_W-1:0]      gap_cnt;
   logic [GAP_W-1:0]      gap_cnt_next;
   logic                  pop;
   logic                  ovf_set;
   logic                  push;
   logic [DATA_WIDTH-1:0] rd_data_c;

   // Flush discards a same-edge word without flagging overflow.
   assign push = wr_valid && !flush;

   sync_fifo_mem #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_mem (
      .clock     (clock),
      .reset     (reset),
      .flush     (flush),
      .push      (push),
      .pop       (pop),
      .wr_data   (wr_data),
      .rd_data_c (rd_data_c),
      .count     (fifo_count),
      .empty     (empty),
      .full      (full)
   );

   // Next-state logic; sink_ready is only consulted while idle.
   always_comb begin
      state_next   = state;
      gap_cnt_next = gap_cnt;
      pop          = 1'b0;
      ovf_set      = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (!empty && sink_ready && !flush) begin
               pop        = 1'b1;
               state_next = ST_LATCH;
            end
         end
         ST_LATCH: begin
            gap_cnt_next = '0;
            state_next   = (LATCH_GAP > 0) ? ST_GAP : ST_IDLE;
         end
         ST_GAP: begin
            if (gap_cnt == GAP_W'(GAP_LAST)) begin
               state_next = ST_IDLE;
            end else begin
               gap_cnt_next = gap_cnt + GAP_W'(1);
            end
         end
         default: state_next = ST_IDLE;
      endcase
      ovf_set = wr_valid && !flush && full && !pop;
   end

   // State, strobe, held command word and sticky overflow.
   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= ST_IDLE;
         gap_cnt    <= '0;
         latch_data <= 1'b0;
         cmd_data   <= '0;
         overflow   <= 1'b0;
      end else begin
         state      <= state_next;
         gap_cnt    <= gap_cnt_next;
         latch_data <= (state_next == ST_LATCH);
         if (pop) cmd_data <= rd_data_c;
         if (ovf_set) begin
            overflow <= 1'b1;
         end else if (clear_overflow) begin
            overflow <= 1'b0;
         end
      end
   end

endmodule : cmd_word_fifo
